// File: rtl/decommutator.sv
// -----------------------------------------------------------------------------
// decommutator
//
// Purpose:
//   Serial-to-parallel frame assembler. A frame is PHASES consecutive enabled
//   samples of DATA_WIDTH bits each. The first sample of a frame lands in the
//   lowest lane of o_data. When a frame completes, the assembled word is
//   presented on o_data one cycle later, together with a single-cycle o_valid
//   pulse. o_clk is a divide-by-PHASES frame clock taken from the phase
//   counter MSB. While the strobe is low, this frame clock is frozen.
//
// Parameters:
//   DATA_WIDTH - bits per serial sample
//   PHASES     - samples per output word; must be a power of two and >= 2
//
// Ports:
//   i_clk   in   sample clock, rising edge
//   i_rst   in   asynchronous, active-high reset
//   i_ena   in   sample strobe; i_data is captured only when high
//   i_sync  in   frame alignment; restarts the frame at lane 0 (needs i_ena)
//   i_data  in   serial sample, DATA_WIDTH bits
//   o_data  out  assembled parallel word, PHASES*DATA_WIDTH bits, registered
//   o_valid out  one-cycle pulse marking a new o_data
//   o_clk   out  frame clock, i_clk/PHASES, 50% duty while enabled
// -----------------------------------------------------------------------------
module decommutator #(
  parameter int DATA_WIDTH = 4,
  parameter int PHASES     = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_ena,
  input  logic                         i_sync,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic [PHASES*DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_clk
);

  localparam int CW = $clog2(PHASES);
  // The top lane is never buffered. It is taken straight from i_data on the
  // completing edge, so the buffer only holds lanes 0..PHASES-2.
  localparam int BW = (PHASES - 1) * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_PHASE = CW'(PHASES - 1);

  logic [CW-1:0] cnt;    // phase of the next sample to be captured
  logic [BW-1:0] lanes;  // lanes 0..PHASES-2 of the frame in progress

  // NOTE: all state here is updated with non-blocking assignments, so every
  // branch sees the pre-edge values of cnt and lanes. The lane buffer is small
  // and must read as zero after reset, so it is reset like any other register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      lanes   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_ena) begin
        if (i_sync) begin
          // Realign: this sample opens a new frame. Whatever partial frame was
          // in progress is dropped. The stale lanes are overwritten in order as
          // the new frame arrives. Sync beats completion at the last phase.
          lanes[DATA_WIDTH-1:0] <= i_data;
          cnt                   <= CW'(1);
        end else if (cnt == LAST_PHASE) begin
          // Frame complete. The buffer is read but left untouched.
          o_data  <= {i_data, lanes};
          o_valid <= 1'b1;
          cnt     <= '0;
        end else begin
          for (int k = 0; k < PHASES - 1; k++) begin
            if (cnt == CW'(k)) begin
              lanes[k*DATA_WIDTH +: DATA_WIDTH] <= i_data;
            end
          end
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // The counter MSB is low for the first half of the frame and high for the
  // second half. It comes straight from a flop, so o_clk has no combinational
  // path from any input.
  assign o_clk = cnt[CW-1];

endmodule

// File: tb/tb_decommutator.sv
// -----------------------------------------------------------------------------
// tb_decommutator
//
// Self-checking bench for decommutator with DATA_WIDTH=4 and PHASES=4.
// The stimulus tasks act as a commutator and emit lane 0 first. For each frame
// that should complete, they push the expected word and the cycle on which it
// must appear. A monitor on the falling edge pops one entry for each o_valid
// pulse and compares it. The bench also tracks the frame phase that the
// stimulus implies, and checks o_clk against it after every edge.
// -----------------------------------------------------------------------------
module tb_decommutator;

  localparam int DW = 4;
  localparam int PH = 4;
  localparam int W  = DW * PH;

  typedef struct {
    logic [W-1:0] word;
    int           cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          sync;
  logic [DW-1:0] din;
  logic [W-1:0]  dout;
  logic          valid;
  logic          fclk;

  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  int   ph     = 0;
  exp_t sb[$];

  decommutator #(.DATA_WIDTH(DW), .PHASES(PH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_ena  (ena),
    .i_sync (sync),
    .i_data (din),
    .o_data (dout),
    .o_valid(valid),
    .o_clk  (fclk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor. Every o_valid pulse must match the oldest pending
  // frame, both in data and in the cycle on which it appears.
  always @(negedge clk) begin
    if (rst === 1'b0 && valid !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("o_data", dout, e.word);
        check("latency", cyc, e.cyc);
      end
    end
  end

  // Drive one enabled sample. The task returns 1 time unit after the capturing
  // edge, with the strobe dropped.
  task automatic sample(input logic [DW-1:0] d, input logic s);
    ena  = 1'b1;
    sync = s;
    din  = d;
    @(posedge clk);
    #1;
    ph   = s ? 1 : (ph + 1) % PH;
    ena  = 1'b0;
    sync = 1'b0;
    check("o_clk", fclk, (ph >= PH / 2));
  endtask

  // Hold the strobe low for n cycles. A sync asserted while disabled must be
  // ignored. The frame clock must stay frozen throughout.
  task automatic stall(input int n, input logic s);
    repeat (n) begin
      sync = s;
      din  = 4'($urandom);
      @(posedge clk);
      #1;
      check("o_clk_frozen", fclk, (ph >= PH / 2));
    end
    sync = 1'b0;
  endtask

  task automatic push_expect(input logic [W-1:0] w);
    exp_t e;
    e.word = w;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  // Commutator: emit w with lane 0 first, back to back.
  task automatic send_word(input logic [W-1:0] w);
    for (int k = 0; k < PH; k++) sample(w[k*DW +: DW], 1'b0);
    push_expect(w);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
  endtask

  initial begin
    rst  = 1'b1;
    ena  = 1'b0;
    sync = 1'b0;
    din  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_data", dout, '0);
    check("rst_o_valid", valid, 1'b0);
    check("rst_o_clk", fclk, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single frame.
    send_word(16'hABCD);
    drain("single_frame");

    // Continuous stream of three frames, one every PH cycles.
    send_word(16'hABCD);
    send_word(16'hDCBA);
    send_word(16'h1234);
    drain("stream");

    // Stall mid-frame. No o_valid and a frozen o_clk during the stall.
    sample(4'hD, 1'b0);
    sample(4'hC, 1'b0);
    stall(3, 1'b0);
    sample(4'hB, 1'b0);
    sample(4'hA, 1'b0);
    push_expect(16'hABCD);
    drain("stall");

    // Sync mid-frame discards the partial frame.
    sample(4'h1, 1'b0);
    sample(4'h2, 1'b0);
    sample(4'hD, 1'b1);
    sample(4'hC, 1'b0);
    sample(4'hB, 1'b0);
    sample(4'hA, 1'b0);
    push_expect(16'hABCD);
    drain("sync_mid");

    // Sync at the last phase beats frame completion.
    sample(4'h1, 1'b0);
    sample(4'h2, 1'b0);
    sample(4'h3, 1'b0);
    sample(4'hD, 1'b1);
    sample(4'hC, 1'b0);
    sample(4'hB, 1'b0);
    sample(4'hA, 1'b0);
    push_expect(16'h4321 ^ 16'h4321 ^ 16'hABCD);
    drain("sync_last");

    // Asynchronous reset mid-frame. The outputs clear without waiting for a clock edge.
    sample(4'h5, 1'b0);
    sample(4'h6, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_o_data", dout, '0);
    check("arst_o_valid", valid, 1'b0);
    check("arst_o_clk", fclk, 1'b0);
    ph = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(16'hABCD);
    drain("after_reset");

    // Round trip through the commutator.
    send_word(16'hABCD);
    send_word(16'hDCBA);
    send_word(16'h1234);
    send_word(16'h4321);
    drain("round_trip");

    // Random words with random stalls. While disabled, sync is randomly asserted and must be ignored.
    for (int n = 0; n < 8; n++) begin
      logic [W-1:0] w;
      w = W'($urandom);
      for (int k = 0; k < PH; k++) begin
        stall($urandom_range(0, 2), 1'($urandom));
        sample(w[k*DW +: DW], 1'b0);
      end
      push_expect(w);
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
